// File: rtl/rand_pkg.sv
// Shared constants, state type and helper functions for the rand_bank
// pseudo-random source: LFSR taps, seed salting and width legality.
package rand_pkg;

  // Golden-ratio salt; decorrelates the per-channel seeds.
  localparam logic [31:0] SALT = 32'h9E37_79B9;

  // Maximal-length Galois tap masks for each supported width.
  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HAVE = 1'b1
  } chan_state_e;

  // Only widths with a known maximal-length tap set are usable.
  function automatic bit width_ok(input int width);
    return (width == 8) || (width == 16) || (width == 24) || (width == 32);
  endfunction

  function automatic logic [31:0] taps(input int width);
    case (width)
      8:       return TAPS_W8;
      16:      return TAPS_W16;
      24:      return TAPS_W24;
      32:      return TAPS_W32;
      default: return 32'h0;
    endcase
  endfunction

  // All-ones in the low `width` bits.
  function automatic logic [31:0] width_mask(input int width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << width) - 32'h1;
  endfunction

  // Salts the seed per channel; a zero result would lock the LFSR, so it
  // is replaced by all-ones.
  function automatic logic [31:0] seed_map(input logic [31:0] seed,
                                           input int          ch,
                                           input int          width);
    logic [31:0] m;
    logic [31:0] salted;
    m      = width_mask(width);
    salted = (seed ^ (32'(ch) * SALT)) & m;
    if (salted == 32'h0) salted = m;
    return salted;
  endfunction

endpackage

// File: rtl/rand_chan.sv
// One channel of rand_bank: a free-running Galois LFSR, a power-of-two
// mask derived from the bound, rejection sampling and a FILL/HAVE output
// stage that presents one accepted value at a time.
module rand_chan
  import rand_pkg::*;
#(
  parameter int          WIDTH  = 16,
  parameter int          OUT_W  = 8,
  parameter logic [31:0] SEED   = 32'h0000_ACE1,
  parameter int          CH_IDX = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_val,
  input  logic [OUT_W-1:0] i_bound,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [OUT_W-1:0] o_rd_data
);

  localparam logic [WIDTH-1:0] TAPS       = WIDTH'(taps(WIDTH));
  localparam logic [WIDTH-1:0] RESET_SEED = WIDTH'(seed_map(SEED, CH_IDX, WIDTH));

  logic [WIDTH-1:0] r_lfsr;
  logic [OUT_W-1:0] r_data;
  chan_state_e      r_state;

  logic [WIDTH-1:0] w_lfsrNext;
  logic [WIDTH-1:0] w_loadSeed;
  logic [OUT_W-1:0] w_boundM1;
  logic [OUT_W-1:0] w_smear;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_cand;
  logic             w_accept;
  logic             w_load;
  chan_state_e      w_nextState;

  assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  assign w_loadSeed = WIDTH'(seed_map(32'(i_seed_val), CH_IDX, WIDTH));

  // LFSR free-runs every cycle; a seed load replaces the step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_lfsr <= RESET_SEED;
    else if (i_seed_load) r_lfsr <= w_loadSeed;
    else                  r_lfsr <= w_lfsrNext;
  end

  // Smallest 2^k-1 covering bound-1; bound 0 means the full output range.
  always_comb begin
    w_boundM1 = i_bound - OUT_W'(1);
    w_smear   = w_boundM1;
    for (int i = 1; i < OUT_W; i++) begin
      w_smear = w_smear | (w_smear >> i);
    end
    if (i_bound == '0) w_mask = '1;
    else               w_mask = w_smear;
  end

  assign w_cand   = r_lfsr[OUT_W-1:0] & w_mask;
  assign w_accept = (i_bound == '0) || (w_cand < i_bound);

  // Next-state and latch decision for the FILL/HAVE output stage.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    if (i_seed_load) begin
      w_nextState = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            w_nextState = ST_HAVE;
            w_load      = 1'b1;
          end
        end
        ST_HAVE: begin
          if (i_rd_ready) begin
            if (w_accept) w_load      = 1'b1;
            else          w_nextState = ST_FILL;
          end
        end
        default: w_nextState = ST_FILL;
      endcase
    end
  end

  // State register for the output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_FILL;
    else          r_state <= w_nextState;
  end

  // Output value register; only changes when a candidate is latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_data <= '0;
    else if (w_load) r_data <= w_cand;
  end

  assign o_rd_valid = (r_state == ST_HAVE);
  assign o_rd_data  = r_data;

endmodule

// File: rtl/rand_bank.sv
// Bank of N_CH independent bounded random channels sharing clock, reset
// and a common runtime re-seed port.
module rand_bank
  import rand_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               N_CH  = 4,
  parameter int               OUT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_seed_load,
  input  logic [WIDTH-1:0]      i_seed_val,
  input  logic [N_CH*OUT_W-1:0] i_bound,
  output logic [N_CH-1:0]       o_rd_valid,
  input  logic [N_CH-1:0]       i_rd_ready,
  output logic [N_CH*OUT_W-1:0] o_rd_data
);

  localparam bit WIDTH_LEGAL = width_ok(WIDTH);

  // Unsupported widths have no maximal-length taps; the bank then stays idle.
  if (WIDTH_LEGAL) begin : g_bank
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
      rand_chan #(
        .WIDTH  (WIDTH),
        .OUT_W  (OUT_W),
        .SEED   (32'(SEED)),
        .CH_IDX (c)
      ) u_chan (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_seed_load (i_seed_load),
        .i_seed_val  (i_seed_val),
        .i_bound     (i_bound[c*OUT_W +: OUT_W]),
        .i_rd_ready  (i_rd_ready[c]),
        .o_rd_valid  (o_rd_valid[c]),
        .o_rd_data   (o_rd_data[c*OUT_W +: OUT_W])
      );
    end
  end else begin : g_illegal_width
    assign o_rd_valid = '0;
    assign o_rd_data  = '0;
  end

endmodule

// File: tb/tb_rand_bank.sv
// Directed self-checking bench for rand_bank: WIDTH=8, two channels,
// SEED=8'h01, so channel 0 starts at 0x01 and channel 1 at 0xB8.
module tb_rand_bank;

  localparam int WIDTH = 8;
  localparam int N_CH  = 2;
  localparam int OUT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  seed_load;
  logic [WIDTH-1:0]      seed_val;
  logic [N_CH*OUT_W-1:0] bound;
  logic [N_CH-1:0]       rd_valid;
  logic [N_CH-1:0]       rd_ready;
  logic [N_CH*OUT_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Hand-derived 0xB8 Galois sequence starting from 0x01.
  logic [7:0] freeSeq [0:12] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3,
                                 8'hE1, 8'hC8, 8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A};

  rand_bank #(
    .WIDTH (WIDTH),
    .N_CH  (N_CH),
    .OUT_W (OUT_W),
    .SEED  (8'h01)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_seed_load (seed_load),
    .i_seed_val  (seed_val),
    .i_bound     (bound),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    seed_load = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (rd_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected %b", rd_valid, 2'b00);
    end
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected %h", rd_data, 16'h0000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    bound    = '0;
    rd_ready = 2'b11;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rd_valid !== 2'b11) begin
        errors++;
        $display("[TB] FAIL free_valid[%0d]: got %b expected %b", i + 1, rd_valid, 2'b11);
      end
      checks++;
      if (rd_data[7:0] !== freeSeq[i]) begin
        errors++;
        $display("[TB] FAIL free_ch0[%0d]: got %h expected %h", i + 1, rd_data[7:0], freeSeq[i]);
      end
      checks++;
      if (rd_data[15:8] !== freeSeq[i+1]) begin
        errors++;
        $display("[TB] FAIL free_ch1[%0d]: got %h expected %h", i + 1, rd_data[15:8], freeSeq[i+1]);
      end
    end
  endtask

  task automatic test_rejection();
    logic       expValid [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] expData  [0:4] = '{8'd1, 8'd1, 8'd28, 8'd28, 8'd23};
    bound    = {8'd1, 8'd40};
    rd_ready = 2'b11;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rd_valid[0] !== expValid[i]) begin
        errors++;
        $display("[TB] FAIL rej_valid[%0d]: got %b expected %b", i + 1, rd_valid[0], expValid[i]);
      end
      if (expValid[i]) begin
        checks++;
        if (rd_data[7:0] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL rej_data[%0d]: got %0d expected %0d", i + 1, rd_data[7:0], expData[i]);
        end
      end
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_data[15:8] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL bound1_ch1[%0d]: got v=%b d=%h expected v=1 d=00", i + 1, rd_valid[1], rd_data[15:8]);
      end
    end
  endtask

  task automatic test_backpressure();
    bound    = '0;
    rd_ready = 2'b00;
    apply_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (rd_valid !== 2'b11 || rd_data !== 16'hB801) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: got v=%b d=%h expected v=11 d=b801", i, rd_valid, rd_data);
      end
    end
    rd_ready = 2'b11;
    step();
    checks++;
    if (rd_data[7:0] !== freeSeq[11]) begin
      errors++;
      $display("[TB] FAIL resume_ch0: got %h expected %h", rd_data[7:0], freeSeq[11]);
    end
    checks++;
    if (rd_data[15:8] !== freeSeq[12]) begin
      errors++;
      $display("[TB] FAIL resume_ch1: got %h expected %h", rd_data[15:8], freeSeq[12]);
    end
  endtask

  task automatic test_period();
    bit seen [0:255];
    int dups;
    int distinct;
    dups     = 0;
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    bound    = '0;
    rd_ready = 2'b11;
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      step();
      if (seen[rd_data[7:0]]) dups++;
      seen[rd_data[7:0]] = 1'b1;
    end
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    checks++;
    if (dups !== 0) begin
      errors++;
      $display("[TB] FAIL period_dups: got %0d expected %0d", dups, 0);
    end
    checks++;
    if (distinct !== 255) begin
      errors++;
      $display("[TB] FAIL period_distinct: got %0d expected %0d", distinct, 255);
    end
    checks++;
    if (seen[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL period_zero: got %b expected %b", seen[0], 1'b0);
    end
    step();
    checks++;
    if (rd_data[7:0] !== 8'h01) begin
      errors++;
      $display("[TB] FAIL period_wrap: got %h expected %h", rd_data[7:0], 8'h01);
    end
    seed_val  = 8'h00;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    checks++;
    if (rd_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL zero_seed_valid: got %b expected %b", rd_valid, 2'b00);
    end
    step();
    checks++;
    if (rd_valid !== 2'b11 || rd_data !== 16'hB9FF) begin
      errors++;
      $display("[TB] FAIL zero_seed_data: got v=%b d=%h expected v=11 d=b9ff", rd_valid, rd_data);
    end
  endtask

  task automatic test_reseed();
    bound    = '0;
    rd_ready = 2'b11;
    apply_reset();
    step();
    step();
    step();
    seed_val  = 8'h01;
    seed_load = 1'b1;
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[7:0] !== 8'h5C) begin
      errors++;
      $display("[TB] FAIL reseed_xfer: got v=%b d=%h expected v=1 d=5c", rd_valid[0], rd_data[7:0]);
    end
    step();
    seed_load = 1'b0;
    checks++;
    if (rd_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reseed_drop: got %b expected %b", rd_valid, 2'b00);
    end
    step();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[7:0] !== 8'h01) begin
      errors++;
      $display("[TB] FAIL reseed_first: got v=%b d=%h expected v=1 d=01", rd_valid[0], rd_data[7:0]);
    end
    step();
    checks++;
    if (rd_data[7:0] !== 8'hB8) begin
      errors++;
      $display("[TB] FAIL reseed_second: got %h expected %h", rd_data[7:0], 8'hB8);
    end
  endtask

  task automatic test_async_reset();
    bound    = '0;
    rd_ready = 2'b11;
    apply_reset();
    step();
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 2'b00 || rd_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_clear: got v=%b d=%h expected v=00 d=0000", rd_valid, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rd_valid !== 2'b11 || rd_data[7:0] !== freeSeq[i] || rd_data[15:8] !== freeSeq[i+1]) begin
        errors++;
        $display("[TB] FAIL async_replay[%0d]: got v=%b d=%h expected v=11 d=%h%h",
                 i + 1, rd_valid, rd_data, freeSeq[i+1], freeSeq[i]);
      end
    end
  endtask

  // Scenario sequence; each task drives and checks its own vectors.
  initial begin
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed_val  = '0;
    bound     = '0;
    rd_ready  = 2'b11;
    $display("[TB] rand_bank directed test start");
    test_reset();
    test_free_run();
    test_rejection();
    test_backpressure();
    test_period();
    test_reseed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
